// File: rtl/tff_sync_counter_pkg.sv
// tff_sync_counter_pkg: shared direction encoding and default width for the TFF counter
package tff_sync_counter_pkg;
  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;
  localparam int DEF_WIDTH = 4;
endpackage

// File: rtl/tff_sync_counter_tff_cell.sv
// tff_cell: single T flip-flop with async clear and a load path that overrides toggling
module tff_cell (
  input  logic clk,
  input  logic clr,
  input  logic t,
  input  logic d_load,
  input  logic ld,
  output logic q
);
  logic q_q, q_d;
  // Next state: load beats toggle, otherwise hold.
  always_comb q_d = ld ? d_load : (t ? ~q_q : q_q);
  // State flop, cleared asynchronously.
  always_ff @(posedge clk or posedge clr)
    if (clr) q_q <= 1'b0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/tff_sync_counter.sv
// tff_sync_counter: up/down counter from T flip-flop cells with load, saturation, tc and wrap pulse
module tff_sync_counter
  import tff_sync_counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SAT_DEF = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);
  if (WIDTH < 2 || SAT_DEF < 0 || SAT_DEF > 1) begin : g_bad_param
    $error("tff_sync_counter: WIDTH must be >= 2 and SAT_DEF 0 or 1");
  end
  logic [WIDTH-1:0] ones, zeros, t;
  logic             step, wrap_q, wrap_d;
  // Toggle-enable prefixes: bit i toggles when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    ones     = '0;
    zeros    = '0;
    ones[0]  = 1'b1;
    zeros[0] = 1'b1;
    for (int k = 1; k < WIDTH; k++) begin
      ones[k]  = ones[k-1] & q[k-1];
      zeros[k] = zeros[k-1] & ~q[k-1];
    end
  end
  // Terminal value depends on the live direction so tc reacts to up immediately.
  always_comb begin
    tc     = (up == DIR_UP) ? &q : ~|q;
    step   = en & ~load & ~(sat_mode & tc);
    t      = step ? ((up == DIR_UP) ? ones : zeros) : '0;
    wrap_d = step & tc;
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk   (clk),
      .clr   (clr),
      .t     (t[i]),
      .d_load(load_val[i]),
      .ld    (load),
      .q     (q[i])
    );
  end
  // Wrap pulse registered on the same edge that rolls q over.
  always_ff @(posedge clk or posedge clr)
    if (clr) wrap_q <= 1'b0;
    else wrap_q <= wrap_d;
  assign wrap = wrap_q;
endmodule
